// File: rtl/ahb_mailbox_responder.sv
// AHB-Lite word-register responder: command mailbox, doorbell, status and response mailbox for a local engine.
// Optional macro AHB_MAILBOX_PRIV_CHECK_EN: unprivileged writes (HPROT[1]==0) get a two-cycle ERROR response.

module ahb_mailbox_responder #(
    parameter int pAHB_ADDR_WIDTH    = 32,
    parameter int pAHB_DATA_WIDTH    = 32,
    parameter int pAHB_HRESP_WIDTH   = 2,
    parameter int pPAYLOAD_SIZE_BITS = 128,
    parameter int pREAD_WAIT_STATES  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          I_hsel,
    input  logic [pAHB_ADDR_WIDTH-1:0]    I_haddr,
    input  logic [1:0]                    I_htrans,
    input  logic                          I_hwrite,
    input  logic [2:0]                    I_hsize,
    input  logic [3:0]                    I_hprot,
    input  logic [pAHB_DATA_WIDTH-1:0]    I_hwdata,
    input  logic                          I_hready,
    output logic [pAHB_DATA_WIDTH-1:0]    O_hrdata,
    output logic                          O_hreadyout,
    output logic [pAHB_HRESP_WIDTH-1:0]   O_hresp,
    output logic [pPAYLOAD_SIZE_BITS-1:0] O_cmd_payload,
    output logic                          O_cmd_valid,
    input  logic                          I_cmd_ready,
    input  logic [pPAYLOAD_SIZE_BITS-1:0] I_rsp_payload,
    input  logic                          I_rsp_valid
);

    localparam logic [3:0]                  cWAIT       = 4'(pREAD_WAIT_STATES);
    localparam logic [pAHB_HRESP_WIDTH-1:0] cRESP_OKAY  = '0;
    localparam logic [pAHB_HRESP_WIDTH-1:0] cRESP_ERROR = pAHB_HRESP_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        ERR1,
        ERR2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [3:0][pAHB_DATA_WIDTH-1:0] r_wdata;
    logic [3:0][pAHB_DATA_WIDTH-1:0] r_rdata;
    logic                            r_cmdPending;
    logic                            r_rspValid;
    logic                            r_errSticky;
    logic                            r_dpValid;
    logic                            r_dpWrite;
    logic [3:0]                      r_dpIndex;
    logic [3:0]                      r_waitCnt;

    logic                            w_capture;
    logic                            w_accept;
    logic                            w_take;
    logic [3:0]                      w_aIndex;
    logic                            w_aIsWdata;
    logic                            w_aIsCtrl;
    logic                            w_aIsStatus;
    logic                            w_aIsRdata;
    logic                            w_aMapped;
    logic                            w_privErr;
    logic                            w_pendNow;
    logic                            w_addrErr;
    logic                            w_dpWriteActive;
    logic                            w_goErr;
    logic                            w_commit;
    logic                            w_commitWdata;
    logic                            w_commitCtrl;
    logic                            w_commitStatus;
    logic                            w_goCommit;
    logic                            w_clrRsp;
    logic                            w_readDone;
    logic                            w_hreadyout;
    logic [pAHB_HRESP_WIDTH-1:0]     w_hresp;
    logic [pAHB_DATA_WIDTH-1:0]      w_status;
    logic [pAHB_DATA_WIDTH-1:0]      w_readWord;
    logic                            w_unused;

    assign w_capture   = I_hsel & I_htrans[1] & I_hready;
    assign w_aIndex    = I_haddr[5:2];
    assign w_aIsWdata  = (w_aIndex[3:2] == 2'b00);
    assign w_aIsCtrl   = (w_aIndex == 4'd4);
    assign w_aIsStatus = (w_aIndex == 4'd5);
    assign w_aIsRdata  = (w_aIndex[3:2] == 2'b10);
    assign w_aMapped   = w_aIsWdata | w_aIsCtrl | w_aIsStatus | w_aIsRdata;

`ifdef AHB_MAILBOX_PRIV_CHECK_EN
    assign w_privErr = I_hwrite & ~I_hprot[1];
`else
    assign w_privErr = 1'b0;
`endif

    assign w_unused = ^{I_haddr[pAHB_ADDR_WIDTH-1:6], I_htrans[0], I_hprot};

    // A GO committing this very cycle already makes the command pending for the next address phase.
    assign w_pendNow = r_cmdPending | w_goCommit;

    assign w_addrErr = (I_hsize != 3'b010)
                     | (I_haddr[1:0] != 2'b00)
                     | ~w_aMapped
                     | (I_hwrite & w_aIsRdata)
                     | (I_hwrite & w_aIsWdata & w_pendNow)
                     | w_privErr;

    assign w_dpWriteActive = r_dpValid & r_dpWrite & (r_state == IDLE);

    // GO lives in HWDATA, so a doorbell while pending can only be rejected in its data phase.
    assign w_goErr        = w_dpWriteActive & (r_dpIndex == 4'd4) & I_hwdata[0] & r_cmdPending;
    assign w_commit       = w_dpWriteActive & ~w_goErr;
    assign w_commitWdata  = w_commit & (r_dpIndex[3:2] == 2'b00);
    assign w_commitCtrl   = w_commit & (r_dpIndex == 4'd4);
    assign w_commitStatus = w_commit & (r_dpIndex == 4'd5);
    assign w_goCommit     = w_commitCtrl & I_hwdata[0];
    assign w_clrRsp       = w_commitCtrl & I_hwdata[1];

    assign w_take     = w_accept & w_capture;
    assign w_readDone = r_dpValid & ~r_dpWrite & w_hreadyout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_hreadyout = 1'b1;
        w_hresp     = cRESP_OKAY;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_goErr) begin
                    w_hreadyout = 1'b0;
                    w_hresp     = cRESP_ERROR;
                    w_nextState = ERR2;
                end else begin
                    w_accept = 1'b1;
                end
            end
            RWAIT: begin
                if (r_waitCnt != 4'd0) begin
                    w_hreadyout = 1'b0;
                end else begin
                    w_accept = 1'b1;
                end
            end
            ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = cRESP_ERROR;
                w_nextState = ERR2;
            end
            ERR2: begin
                w_hresp  = cRESP_ERROR;
                w_accept = 1'b1;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (w_accept) begin
            if (w_capture & w_addrErr) begin
                w_nextState = ERR1;
            end else if (w_capture & ~I_hwrite & (cWAIT != 4'd0)) begin
                w_nextState = RWAIT;
            end else begin
                w_nextState = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dpValid <= 1'b0;
            r_dpWrite <= 1'b0;
            r_dpIndex <= 4'd0;
        end else if (w_take) begin
            r_dpValid <= ~w_addrErr;
            r_dpWrite <= I_hwrite;
            r_dpIndex <= w_aIndex;
        end else if (w_hreadyout | w_goErr) begin
            r_dpValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= 4'd0;
        end else if ((r_state == RWAIT) && (r_waitCnt != 4'd0)) begin
            r_waitCnt <= r_waitCnt - 4'd1;
        end else if (w_take & ~w_addrErr & ~I_hwrite) begin
            r_waitCnt <= cWAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdata <= '0;
        end else if (w_commitWdata) begin
            r_wdata[r_dpIndex[1:0]] <= I_hwdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmdPending <= 1'b0;
        end else if (w_goCommit) begin
            r_cmdPending <= 1'b1;
        end else if (r_cmdPending & I_cmd_ready) begin
            r_cmdPending <= 1'b0;
        end
    end

    // A response arriving alongside CLR_RSP is kept: losing engine output is worse than a stale clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= '0;
            r_rspValid <= 1'b0;
        end else if (I_rsp_valid) begin
            r_rdata    <= I_rsp_payload;
            r_rspValid <= 1'b1;
        end else if (w_clrRsp) begin
            r_rdata    <= '0;
            r_rspValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errSticky <= 1'b0;
        end else if ((w_take & w_addrErr) | w_goErr) begin
            r_errSticky <= 1'b1;
        end else if (w_commitStatus) begin
            r_errSticky <= 1'b0;
        end
    end

    always_comb begin
        w_status      = '0;
        w_status[2:0] = {r_errSticky, r_rspValid, r_cmdPending};
        w_readWord    = '0;
        case (r_dpIndex)
            4'd0, 4'd1, 4'd2, 4'd3:   w_readWord = r_wdata[r_dpIndex[1:0]];
            4'd5:                     w_readWord = w_status;
            4'd8, 4'd9, 4'd10, 4'd11: w_readWord = r_rdata[r_dpIndex[1:0]];
            default:                  w_readWord = '0;
        endcase
    end

    assign O_hrdata      = w_readDone ? w_readWord : '0;
    assign O_hreadyout   = w_hreadyout;
    assign O_hresp       = w_hresp;
    assign O_cmd_payload = r_wdata;
    assign O_cmd_valid   = r_cmdPending;

endmodule
